// File: rtl/rtc_hour_reader_pkg.sv
// -----------------------------------------------------------------------------
// rtc_hour_reader_pkg
//
// Constants and types shared by the RTC hours sequencers:
//   - RTC register address constants. The hours address is shared with the
//     hours-write sequencer.
//   - State encoding of the read sequencer FSM.
//   - Maximum legal BCD hour value (24-hour clock).
//   - Small helper functions used for parameter arithmetic and BCD checks.
// -----------------------------------------------------------------------------
package rtc_hour_reader_pkg;

    // RTC register map
    localparam logic [7:0] RTC_ADDR_HOURS = 8'h23;

    // Largest hours value the RTC may legally return (23h, BCD)
    localparam logic [7:0] RTC_MAX_HOUR   = 8'h23;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_ADDR_ENC = 2'd1;
    localparam logic [1:0] ST_READ_ENC = 2'd2;
    localparam logic [1:0] ST_DONE_ENC = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_ADDR = ST_ADDR_ENC,
        ST_READ = ST_READ_ENC,
        ST_DONE = ST_DONE_ENC
    } rd_state_t;

    // Larger of two integers; used to size the phase counter
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // True when a nibble is a legal BCD digit
    function automatic logic bcd_digit_ok(input logic [3:0] d);
        return (d <= 4'd9);
    endfunction

endpackage : rtc_hour_reader_pkg

// File: rtl/rtc_hour_reader_bcd_hour_check.sv
// -----------------------------------------------------------------------------
// bcd_hour_check
//
// Purely combinational validity check of a BCD hours byte. A byte is valid
// when both nibbles are decimal digits (0..9) and the value does not exceed
// the maximum hour (8'h23).
//
// Ports:
//   i_hour  [7:0]  candidate BCD hours byte
//   o_valid        1 = byte is a legal hour
// -----------------------------------------------------------------------------
module bcd_hour_check
    import rtc_hour_reader_pkg::*;
(
    input  logic [7:0] i_hour,
    output logic       o_valid
);

    logic [1:0] w_digit_ok;

    // One digit check per nibble
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_digit
            assign w_digit_ok[gi] = bcd_digit_ok(i_hour[gi*4 +: 4]);
        end
    endgenerate

    // With both digits legal, a plain binary compare orders BCD values correctly
    assign o_valid = (&w_digit_ok) && (i_hour <= RTC_MAX_HOUR);

endmodule : bcd_hour_check

// File: rtl/rtc_hour_reader.sv
// -----------------------------------------------------------------------------
// rtc_hour_reader
//
// Read-side sequencer for the RTC multiplexed address/data bus. A start pulse
// (accepted only in IDLE with enable high) launches:
//   ADDR phase (ADDR_CYC cycles): A_D=0, direccion=REG_ADDR, flag_addr=1
//   READ phase (RD_CYC cycles)  : A_D=1, direccion=0,        flag_read=1
//   DONE (1 cycle)              : done pulse, horas updated if accepted
// dato_in is sampled on the last read-phase edge. All outputs are registered.
// Bus arbitration against the hours writer is handled outside this block.
//
// Configuration macro:
//   RTC_HOUR_BCD_CHECK_EN  defined   -> captured byte is validated by
//                                       bcd_hour_check; a rejected byte
//                                       pulses err with done and horas is
//                                       left unchanged.
//                          undefined -> byte always captured, err stays 0.
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous reset, active low
//   enable     low = synchronous abort back to IDLE (horas retained)
//   start      request one hours read (IDLE only)
//   dato_in    [7:0] read-back data from the RTC bus
//   A_D        0 = address phase, 1 = data phase
//   W_R        always 0 (read)
//   direccion  [7:0] REG_ADDR during the address phase, else 0
//   flag_addr  high during the address phase
//   flag_read  high during the read phase
//   busy       high in ADDR, READ and DONE
//   horas      [7:0] last accepted BCD hours value
//   done       one-cycle completion pulse
//   err        one-cycle pulse with done when the byte was rejected
// -----------------------------------------------------------------------------
module rtc_hour_reader
    import rtc_hour_reader_pkg::*;
#(
    parameter logic [7:0] REG_ADDR = RTC_ADDR_HOURS,
    parameter int         ADDR_CYC = 2,
    parameter int         RD_CYC   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       start,
    input  logic [7:0] dato_in,
    output logic       A_D,
    output logic       W_R,
    output logic [7:0] direccion,
    output logic       flag_addr,
    output logic       flag_read,
    output logic       busy,
    output logic [7:0] horas,
    output logic       done,
    output logic       err
);

    localparam int CNT_W = $clog2(max_int(ADDR_CYC, RD_CYC)) + 1;
    localparam logic [CNT_W-1:0] ADDR_LOAD = CNT_W'(ADDR_CYC - 1);
    localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(RD_CYC - 1);

    rd_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_a_d;
    logic [7:0]       r_direccion;
    logic             r_flag_addr;
    logic             r_flag_read;
    logic             r_busy;
    logic [7:0]       r_horas;
    logic             r_done;
    logic             r_err;

    logic             w_accept;

`ifdef RTC_HOUR_BCD_CHECK_EN
    logic w_valid;

    bcd_hour_check u_bcd_hour_check (
        .i_hour  (dato_in),
        .o_valid (w_valid)
    );

    assign w_accept = w_valid;
`else
    assign w_accept = 1'b1;
`endif

    // Single registered FSM; outputs are loaded on the edge that enters each
    // state so they line up with the state for its whole duration.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_a_d       <= 1'b0;
            r_direccion <= 8'h00;
            r_flag_addr <= 1'b0;
            r_flag_read <= 1'b0;
            r_busy      <= 1'b0;
            r_horas     <= 8'h00;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else if (!enable) begin
            // Abort: everything but the last accepted hours value is cleared
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_a_d       <= 1'b0;
            r_direccion <= 8'h00;
            r_flag_addr <= 1'b0;
            r_flag_read <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state     <= ST_ADDR;
                        r_cnt       <= ADDR_LOAD;
                        r_a_d       <= 1'b0;
                        r_direccion <= REG_ADDR;
                        r_flag_addr <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (r_cnt == '0) begin
                        r_state     <= ST_READ;
                        r_cnt       <= RD_LOAD;
                        r_a_d       <= 1'b1;
                        r_direccion <= 8'h00;
                        r_flag_addr <= 1'b0;
                        r_flag_read <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_READ: begin
                    if (r_cnt == '0) begin
                        // Final read-phase edge: capture and report
                        r_state     <= ST_DONE;
                        r_cnt       <= '0;
                        r_a_d       <= 1'b0;
                        r_flag_read <= 1'b0;
                        r_done      <= 1'b1;
                        r_err       <= ~w_accept;
                        if (w_accept) begin
                            r_horas <= dato_in;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= '0;
                    r_a_d       <= 1'b0;
                    r_direccion <= 8'h00;
                    r_flag_addr <= 1'b0;
                    r_flag_read <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign A_D       = r_a_d;
    assign W_R       = 1'b0;
    assign direccion = r_direccion;
    assign flag_addr = r_flag_addr;
    assign flag_read = r_flag_read;
    assign busy      = r_busy;
    assign horas     = r_horas;
    assign done      = r_done;
    assign err       = r_err;

endmodule : rtc_hour_reader

// File: doc/rtc_hour_reader.md
# rtc_hour_reader

Read-side sequencer for the RTC's multiplexed address/data bus. On a start pulse it drives an address phase selecting the hours register, then a read phase, and captures the BCD hours byte returned on the bus. It sits beside the hours-write sequencer in the general RTC/VGA state machine and supplies the `horas` value that the writer and the VGA display consume. Bus arbitration between this block and the writer is external.

## Interface

**Parameters**
- `REG_ADDR`, default 8'h23: RTC hours register address driven during the address phase.
- `ADDR_CYC`, default 2: cycles the address phase is held (≥1).
- `RD_CYC`, default 3: cycles the read phase is held (≥1). Data is sampled on the last cycle.

**Ports**
- `clk`, input, 1: the single clock; all logic on the rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `enable`, input, 1: block enable. Low acts as a synchronous abort/clear of the FSM.
- `start`, input, 1: request one hours read. Sampled only in IDLE.
- `dato_in`, input, 8: bus read-back data from the RTC.
- `A_D`, output, 1: 0 = address phase, 1 = data phase.
- `W_R`, output, 1: always 0 (read).
- `direccion`, output, 8: REG_ADDR during the address phase, 8'h00 otherwise.
- `flag_addr`, output, 1: high during the address phase.
- `flag_read`, output, 1: high during the read phase.
- `busy`, output, 1: high from the cycle after start is accepted until done.
- `horas`, output, 8: last accepted BCD hours value.
- `done`, output, 1: one-cycle pulse when a transaction completes.
- `err`, output, 1: one-cycle pulse, coincident with `done`, when the captured byte is rejected.

## Operation

- All outputs are registered. Reset value of every output is 0, including `horas` = 8'h00.
- FSM states:
  - IDLE: start=1 and enable=1 → ADDR, load phase counter = ADDR_CYC-1.
  - ADDR: A_D=0, direccion=REG_ADDR, flag_addr=1. When the counter reaches 0 → READ, load RD_CYC-1.
  - READ: A_D=1, direccion=0, flag_read=1. When the counter reaches 0, sample `dato_in` → DONE.
  - DONE: one cycle. Pulses done (and err if rejected), updates horas if accepted, then → IDLE.
- Phase counter width is $clog2(max(ADDR_CYC,RD_CYC))+1. It counts down with no wrap; it is reloaded on every state entry.
- busy=1 in ADDR, READ and DONE.
- start while busy is ignored, not queued.
- enable=0 in any state: the next edge forces IDLE and clears all bus outputs, flags, busy, done and err. horas is retained. Only reset clears horas.
- reset low mid-transaction: the next edge returns everything to reset values, and no done is issued.
- start=1 with enable=0 in the same cycle: ignored.

## Timing

- start sampled at edge k. The address phase is visible on edges k+1 … k+ADDR_CYC. The read phase is visible on edges k+ADDR_CYC+1 … k+ADDR_CYC+RD_CYC.
- dato_in is sampled at the final read-phase edge.
- done, err and the new horas are visible one cycle after the final read-phase edge, i.e. at edge k+ADDR_CYC+RD_CYC+1.
- Total latency with defaults: 6 cycles from start to done.
- Back-to-back reads: the earliest next start is accepted in the cycle after done (IDLE).

## Configuration

- `RTC_HOUR_BCD_CHECK_EN` defined: the captured byte is rejected if either nibble is greater than 9 or the value is greater than 8'h23. On rejection, err=1 with done, and horas keeps its old value.
- `RTC_HOUR_BCD_CHECK_EN` undefined: the byte is captured unconditionally and err is held at 0.

## Structure

- A shared RTC package holds:
  - register address constants (hours 8'h23, shared with the writer);
  - the state encoding localparams;
  - the max-hour constant 8'h23.
- One sub-module, `bcd_hour_check`: combinational validity check on 8 bits. It is instantiated only under the macro.

## Test plan

- Reset: hold reset=0 for 3 cycles, with start=1 and dato_in=8'h15 → all outputs 0 and horas=8'h00. No done pulse.
- Nominal read: start pulse, dato_in=8'h17 → A_D=0 and direccion=8'h23 for 2 cycles; A_D=1 for 3 cycles; done at cycle 6; horas=8'h17; err=0; W_R=0 throughout.
- Boundary values: dato_in=8'h23, then 8'h00 → both accepted. dato_in=8'h24, or 8'h1A with the macro → err=1 and horas unchanged. The same values without the macro → horas=8'h24 / 8'h1A and err=0.
- Abort: enable=0 on the 2nd read-phase cycle → the next edge shows IDLE with outputs cleared. No done pulse. horas holds its previous value (8'h17).
- start while busy: a second start pulse during the address phase → exactly one done. A start in the cycle after done begins a new read.
- Parameter sweep: ADDR_CYC=1, RD_CYC=1 → done at start+3 with correct capture.
